// File: rtl/pipelined_addsub.sv
// ============================================================================
// Module   : pipelined_addsub
// Function : Pipelined signed/unsigned adder-subtractor, one BLOCK-bit slice
//            per stage, with saturation, carry/zero flags and full-pipe stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 8,
    parameter int SAT_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_sub,
    input  logic             ctrl_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow,
    output logic             carry_out,
    output logic             zero
);

    localparam int c_NB = WIDTH / BLOCK;
    localparam int c_NR = (c_NB > 1) ? (c_NB - 1) : 1;

    logic                 w_advance;

    // Per-stage inputs (source) and slice-adder results (next).
    logic [c_NB-1:0]      w_src_v;
    logic [c_NB-1:0]      w_src_c;
    logic [c_NB-1:0]      w_src_sat;
    logic [WIDTH-1:0]     w_src_a [c_NB];
    logic [WIDTH-1:0]     w_src_b [c_NB];
    logic [WIDTH-1:0]     w_src_s [c_NB];
    logic [WIDTH-1:0]     w_nx_s  [c_NB];
    logic [c_NB-1:0]      w_nx_c;

    // Inter-stage registers: stage k result feeds stage k+1.
    logic [c_NR-1:0]      r_p_v;
    logic [c_NR-1:0]      r_p_c;
    logic [c_NR-1:0]      r_p_sat;
    logic [WIDTH-1:0]     r_p_a [c_NR];
    logic [WIDTH-1:0]     r_p_b [c_NR];
    logic [WIDTH-1:0]     r_p_s [c_NR];

    logic                 r_out_valid;
    logic [WIDTH-1:0]     r_result;
    logic                 r_ovf;
    logic                 r_cout;
    logic                 r_zero;

    logic                 w_top_a;
    logic                 w_top_b;
    logic [WIDTH-1:0]     w_raw;
    logic                 w_ovf;
    logic                 w_do_sat;
    logic [WIDTH-1:0]     w_result;

    assign w_advance = ~r_out_valid | out_ready;
    assign in_ready  = w_advance;

    always_comb begin
        w_src_v   = '0;
        w_src_c   = '0;
        w_src_sat = '0;
        for (int k = 0; k < c_NB; k++) begin
            w_src_a[k] = '0;
            w_src_b[k] = '0;
            w_src_s[k] = '0;
        end
        // Subtract is A + ~B + 1: the +1 enters as stage-0 carry-in.
        w_src_v[0]   = in_valid;
        w_src_c[0]   = ctrl_sub;
        w_src_sat[0] = ctrl_sat;
        w_src_a[0]   = data_operandA;
        w_src_b[0]   = ctrl_sub ? ~data_operandB : data_operandB;
        for (int k = 1; k < c_NB; k++) begin
            w_src_v[k]   = r_p_v[k-1];
            w_src_c[k]   = r_p_c[k-1];
            w_src_sat[k] = r_p_sat[k-1];
            w_src_a[k]   = r_p_a[k-1];
            w_src_b[k]   = r_p_b[k-1];
            w_src_s[k]   = r_p_s[k-1];
        end
    end

    always_comb begin
        logic [BLOCK:0] v_sum;
        w_nx_c = '0;
        v_sum  = '0;
        for (int k = 0; k < c_NB; k++) begin
            v_sum = {1'b0, w_src_a[k][k*BLOCK +: BLOCK]}
                  + {1'b0, w_src_b[k][k*BLOCK +: BLOCK]}
                  + {{BLOCK{1'b0}}, w_src_c[k]};
            w_nx_s[k]                     = w_src_s[k];
            w_nx_s[k][k*BLOCK +: BLOCK]   = v_sum[BLOCK-1:0];
            w_nx_c[k]                     = v_sum[BLOCK];
        end
    end

    // Final stage: flags and saturation are resolved before the output register.
    assign w_top_a  = w_src_a[c_NB-1][WIDTH-1];
    assign w_top_b  = w_src_b[c_NB-1][WIDTH-1];
    assign w_raw    = w_nx_s[c_NB-1];
    assign w_ovf    = (w_top_a == w_top_b) & (w_raw[WIDTH-1] != w_top_a);
    assign w_do_sat = (SAT_EN != 0) & w_src_sat[c_NB-1] & w_ovf;
    assign w_result = !w_do_sat ? w_raw
                    : (w_top_a ? {1'b1, {(WIDTH-1){1'b0}}}
                               : {1'b0, {(WIDTH-1){1'b1}}});

    always_ff @(posedge clock) begin
        if (reset) begin
            r_p_v       <= '0;
            r_p_c       <= '0;
            r_p_sat     <= '0;
            for (int k = 0; k < c_NR; k++) begin
                r_p_a[k] <= '0;
                r_p_b[k] <= '0;
                r_p_s[k] <= '0;
            end
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_advance) begin
            for (int k = 0; k < c_NB - 1; k++) begin
                r_p_v[k]   <= w_src_v[k];
                r_p_c[k]   <= w_nx_c[k];
                r_p_sat[k] <= w_src_sat[k];
                r_p_a[k]   <= w_src_a[k];
                r_p_b[k]   <= w_src_b[k];
                r_p_s[k]   <= w_nx_s[k];
            end
            r_out_valid <= w_src_v[c_NB-1];
            r_result    <= w_result;
            r_ovf       <= w_ovf;
            r_cout      <= w_nx_c[c_NB-1];
            r_zero      <= (w_result == '0);
        end
    end

    assign out_valid   = r_out_valid;
    assign data_result = r_result;
    assign overflow    = r_ovf;
    assign carry_out   = r_cout;
    assign zero        = r_zero;

endmodule

`default_nettype wire
